// File: rtl/startup_seq_ctrl_if.sv
// Signal bundle between the startup sequencer and the STARTUP_VIRTEX6 primitive.
// The sequencer uses master; the primitive side (or a bench) uses slave.
interface startup_seq_ctrl_if;
    logic eos_i;
    logic preq_i;
    logic gts_o;
    logic usrdoneo_o;
    logic usrdonets_o;
    logic usrcclko_o;
    logic usrcclkts_o;
    logic pack_o;

    modport master (
        input  eos_i, preq_i,
        output gts_o, usrdoneo_o, usrdonets_o, usrcclko_o, usrcclkts_o, pack_o
    );

    modport slave (
        output eos_i, preq_i,
        input  gts_o, usrdoneo_o, usrdonets_o, usrcclko_o, usrcclkts_o, pack_o
    );
endinterface

// File: rtl/startup_seq_ctrl.sv
// Post-configuration startup sequencer: EOS settle, GTS release, user CCLK burst,
// DONE, system reset release, then PREQ/PACK reprogram handshake.
module startup_seq_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int SETTLE_CYCLES   = 16,
    parameter int GTS_HOLD_CYCLES = 8,
    parameter int CCLK_PULSES     = 4,
    parameter int CCLK_DIV        = 2,
    parameter int PACK_CYCLES     = 4,
    parameter int CNT_W           = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    startup_seq_ctrl_if.master  prim,
    input  logic                prog_allow_i,
    output logic                sys_rst_n_o,
    output logic                ready_o,
    output logic                preq_pending_o,
    output logic [2:0]          state_o
);
    typedef enum logic [2:0] {
        WAIT_EOS  = 3'd0,
        HOLD      = 3'd1,
        GTS_WAIT  = 3'd2,
        BURST     = 3'd3,
        DONE      = 3'd4,
        RUN       = 3'd5,
        PACK      = 3'd6,
        PROG_WAIT = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LEN = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] GTS_LEN    = CNT_W'(GTS_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] BURST_LEN  = CNT_W'(2 * CCLK_DIV * CCLK_PULSES);
    localparam logic [CNT_W-1:0] HALF_LEN   = CNT_W'(CCLK_DIV);
    localparam logic [CNT_W-1:0] PACK_LEN   = CNT_W'(PACK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [SYNC_STAGES-1:0] eos_sync_reg;
    logic [SYNC_STAGES-1:0] preq_sync_reg;
    logic                   eos_s;
    logic                   preq_s;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] half_reg, half_next;
    logic             cnt_last;

    logic gts_reg, gts_next;
    logic usrdoneo_reg, usrdoneo_next;
    logic usrdonets_reg, usrdonets_next;
    logic cclk_reg, cclk_next;
    logic cclkts_reg, cclkts_next;
    logic pack_reg, pack_next;
    logic sys_rst_n_reg, sys_rst_n_next;
    logic ready_reg, ready_next;
    logic pending_reg, pending_next;

    assign eos_s    = eos_sync_reg[SYNC_STAGES-1];
    assign preq_s   = preq_sync_reg[SYNC_STAGES-1];
    // A loaded count of 0 or 1 both mean "leave after this cycle".
    assign cnt_last = (cnt_reg <= CNT_ONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            eos_sync_reg  <= '0;
            preq_sync_reg <= '0;
            state_reg     <= WAIT_EOS;
            cnt_reg       <= '0;
            half_reg      <= '0;
            gts_reg       <= 1'b1;
            usrdoneo_reg  <= 1'b0;
            usrdonets_reg <= 1'b1;
            cclk_reg      <= 1'b0;
            cclkts_reg    <= 1'b1;
            pack_reg      <= 1'b0;
            sys_rst_n_reg <= 1'b0;
            ready_reg     <= 1'b0;
            pending_reg   <= 1'b0;
        end else begin
            eos_sync_reg  <= {eos_sync_reg[SYNC_STAGES-2:0], prim.eos_i};
            preq_sync_reg <= {preq_sync_reg[SYNC_STAGES-2:0], prim.preq_i};
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            half_reg      <= half_next;
            gts_reg       <= gts_next;
            usrdoneo_reg  <= usrdoneo_next;
            usrdonets_reg <= usrdonets_next;
            cclk_reg      <= cclk_next;
            cclkts_reg    <= cclkts_next;
            pack_reg      <= pack_next;
            sys_rst_n_reg <= sys_rst_n_next;
            ready_reg     <= ready_next;
            pending_reg   <= pending_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        half_next  = '0;
        cclk_next  = 1'b0;

        case (state_reg)
            WAIT_EOS: begin
                if (eos_s) begin
                    state_next = HOLD;
                    cnt_next   = SETTLE_LEN;
                end
            end
            HOLD: begin
                if (!eos_s) begin
                    state_next = WAIT_EOS;
                    cnt_next   = '0;
                end else if (cnt_last) begin
                    state_next = GTS_WAIT;
                    cnt_next   = GTS_LEN;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            GTS_WAIT: begin
                if (!eos_s) begin
                    state_next = WAIT_EOS;
                    cnt_next   = '0;
                end else if (cnt_last) begin
                    state_next = BURST;
                    cnt_next   = BURST_LEN;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            BURST: begin
                if (!eos_s) begin
                    state_next = WAIT_EOS;
                    cnt_next   = '0;
                end else if (cnt_last) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = eos_s ? RUN : WAIT_EOS;
                cnt_next   = '0;
            end
            RUN: begin
                // Level-serviced: a request already high on entry is taken at once.
                if (preq_s && prog_allow_i) begin
                    state_next = PACK;
                    cnt_next   = PACK_LEN;
                end
            end
            PACK: begin
                if (cnt_last) begin
                    state_next = PROG_WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            PROG_WAIT: state_next = PROG_WAIT;
            default: begin
                state_next = WAIT_EOS;
                cnt_next   = '0;
            end
        endcase

        // USRCCLKO: high for the first CCLK_DIV cycles of each period, low on any exit.
        if (state_next == BURST && BURST_LEN != '0) begin
            if (state_reg != BURST) begin
                cclk_next = 1'b1;
                half_next = CNT_ONE;
            end else if (half_reg == HALF_LEN) begin
                cclk_next = !cclk_reg;
                half_next = CNT_ONE;
            end else begin
                cclk_next = cclk_reg;
                half_next = half_reg + 1'b1;
            end
        end

        gts_next       = 1'b1;
        usrdoneo_next  = 1'b0;
        usrdonets_next = 1'b1;
        cclkts_next    = 1'b1;
        pack_next      = 1'b0;
        sys_rst_n_next = 1'b0;
        ready_next     = 1'b0;
        case (state_next)
            GTS_WAIT: gts_next = 1'b0;
            BURST: begin
                gts_next    = 1'b0;
                cclkts_next = 1'b0;
            end
            DONE: begin
                gts_next       = 1'b0;
                usrdoneo_next  = 1'b1;
                usrdonets_next = 1'b0;
            end
            RUN: begin
                gts_next       = 1'b0;
                usrdoneo_next  = 1'b1;
                usrdonets_next = 1'b0;
                sys_rst_n_next = 1'b1;
                ready_next     = 1'b1;
            end
            PACK: begin
                gts_next       = 1'b0;
                usrdoneo_next  = 1'b1;
                usrdonets_next = 1'b0;
                pack_next      = 1'b1;
                sys_rst_n_next = 1'b1;
            end
            default: ;
        endcase
        pending_next = (state_next == RUN) && preq_s && !prog_allow_i;
    end

    assign prim.gts_o       = gts_reg;
    assign prim.usrdoneo_o  = usrdoneo_reg;
    assign prim.usrdonets_o = usrdonets_reg;
    assign prim.usrcclko_o  = cclk_reg;
    assign prim.usrcclkts_o = cclkts_reg;
    assign prim.pack_o      = pack_reg;
    assign sys_rst_n_o      = sys_rst_n_reg;
    assign ready_o          = ready_reg;
    assign preq_pending_o   = pending_reg;
    assign state_o          = state_reg;
endmodule

// File: tb/tb_startup_seq_ctrl.sv
// Directed bench for startup_seq_ctrl: default-parameter instance plus an
// instance with zero-length settle/hold/burst.
module tb_startup_seq_ctrl;
    localparam logic [8:0] RST_OUTS = 9'b101010000;

    logic       clock;
    logic       reset_n;
    logic       prog_allow;
    logic       sys_rst_n_a, ready_a, pend_a;
    logic       sys_rst_n_b, ready_b, pend_b;
    logic [2:0] state_a, state_b;
    logic [8:0] obs_a, obs_b;
    int         checks = 0;
    int         errors = 0;

    startup_seq_ctrl_if if_a ();
    startup_seq_ctrl_if if_b ();

    startup_seq_ctrl dut_a (
        .clock(clock), .reset_n(reset_n), .prim(if_a), .prog_allow_i(prog_allow),
        .sys_rst_n_o(sys_rst_n_a), .ready_o(ready_a), .preq_pending_o(pend_a),
        .state_o(state_a)
    );

    startup_seq_ctrl #(.SETTLE_CYCLES(0), .GTS_HOLD_CYCLES(0), .CCLK_PULSES(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .prim(if_b), .prog_allow_i(prog_allow),
        .sys_rst_n_o(sys_rst_n_b), .ready_o(ready_b), .preq_pending_o(pend_b),
        .state_o(state_b)
    );

    // {gts, usrdoneo, usrdonets, usrcclko, usrcclkts, pack, sys_rst_n, ready, pending}
    assign obs_a = {if_a.gts_o, if_a.usrdoneo_o, if_a.usrdonets_o, if_a.usrcclko_o,
                    if_a.usrcclkts_o, if_a.pack_o, sys_rst_n_a, ready_a, pend_a};
    assign obs_b = {if_b.gts_o, if_b.usrdoneo_o, if_b.usrdonets_o, if_b.usrcclko_o,
                    if_b.usrcclkts_o, if_b.pack_o, sys_rst_n_b, ready_b, pend_b};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected timeline after edge Ek, E0 being the first edge that samples eos_i=1.
    function automatic logic [2:0] tl_state_a(input int k);
        if (k < 2)  return 3'd0;
        if (k < 18) return 3'd1;
        if (k < 26) return 3'd2;
        if (k < 42) return 3'd3;
        if (k == 42) return 3'd4;
        return 3'd5;
    endfunction

    function automatic logic [8:0] tl_outs_a(input int k);
        logic burst, cclk, run;
        burst = (k >= 26) && (k <= 41);
        cclk  = burst && (((k - 26) % 4) < 2);
        run   = (k >= 43);
        return {(k < 18), (k >= 42), (k < 42), cclk, !burst, 1'b0, run, run, 1'b0};
    endfunction

    function automatic logic [2:0] tl_state_b(input int k);
        if (k < 2) return 3'd0;
        if (k < 6) return 3'(k - 1);
        return 3'd5;
    endfunction

    function automatic logic [8:0] tl_outs_b(input int k);
        logic run;
        run = (k >= 6);
        return {(k < 3), (k >= 5), (k < 5), 1'b0, (k != 4), 1'b0, run, run, 1'b0};
    endfunction

    task automatic run_seq(input int kmax, input bit with_b, input string ph);
        int   pulses;
        logic prev;
        pulses = 0;
        prev   = 1'b0;
        if_a.eos_i = 1'b1;
        if (with_b) if_b.eos_i = 1'b1;
        for (int k = 0; k <= kmax; k++) begin
            tick();
            chk($sformatf("%s a_state k=%0d", ph, k), state_a, tl_state_a(k));
            chk($sformatf("%s a_outs k=%0d", ph, k), obs_a, tl_outs_a(k));
            if (with_b) begin
                chk($sformatf("%s b_state k=%0d", ph, k), state_b, tl_state_b(k));
                chk($sformatf("%s b_outs k=%0d", ph, k), obs_b, tl_outs_b(k));
            end
            if (if_a.usrcclko_o && !prev) pulses++;
            prev = if_a.usrcclko_o;
        end
        if (kmax >= 43) chk($sformatf("%s cclk_pulses", ph), pulses, 4);
        $display("seq %s: %0d cycles checked", ph, kmax + 1);
    endtask

    initial begin
        reset_n    = 1'b1;
        prog_allow = 1'b0;
        if_a.eos_i = 1'b0; if_a.preq_i = 1'b0;
        if_b.eos_i = 1'b0; if_b.preq_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("reset a_state", state_a, 3'd0);
        chk("reset a_outs", obs_a, RST_OUTS);
        chk("reset b_state", state_b, 3'd0);
        chk("reset b_outs", obs_b, RST_OUTS);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("idle a_state", state_a, 3'd0);
        chk("idle a_outs", obs_a, RST_OUTS);
        $display("txn reset: done");

        // Full startup on both instances.
        run_seq(44, 1'b1, "main");

        // PREQ held with no permission, then permission granted.
        if_a.preq_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("blocked pending i=%0d", i), pend_a, (i >= 3));
            chk($sformatf("blocked pack i=%0d", i), if_a.pack_o, 1'b0);
            chk($sformatf("blocked state i=%0d", i), state_a, 3'd5);
        end
        prog_allow = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk($sformatf("pack state j=%0d", j), state_a, (j <= 4) ? 3'd6 : 3'd7);
            chk($sformatf("pack pulse j=%0d", j), if_a.pack_o, (j <= 4));
            chk($sformatf("pack pending j=%0d", j), pend_a, 1'b0);
            chk($sformatf("pack sys_rst_n j=%0d", j), sys_rst_n_a, (j <= 4));
            chk($sformatf("pack gts j=%0d", j), if_a.gts_o, (j > 4));
            chk($sformatf("pack ready j=%0d", j), ready_a, 1'b0);
        end
        chk("prog_wait usrdonets", if_a.usrdonets_o, 1'b1);
        if_a.eos_i  = 1'b0;
        if_a.preq_i = 1'b0;
        repeat (5) tick();
        chk("prog_wait ignores eos", state_a, 3'd7);
        $display("txn preq/pack: done");

        // EOS glitch shorter than the settle window.
        reset_n    = 1'b0;
        prog_allow = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        if_a.eos_i = 1'b1;
        for (int g = 0; g <= 11; g++) begin
            if (g == 5) if_a.eos_i = 1'b0;
            tick();
            chk($sformatf("glitch state g=%0d", g), state_a, (g >= 2 && g <= 6) ? 3'd1 : 3'd0);
            chk($sformatf("glitch outs g=%0d", g), obs_a, RST_OUTS);
        end
        $display("txn eos glitch: done");

        // EOS lost three cycles into the burst, then full replay.
        repeat (4) tick();
        run_seq(28, 1'b0, "abort");
        if_a.eos_i = 1'b0;
        tick();
        chk("abort e29 state", state_a, tl_state_a(29));
        chk("abort e29 outs", obs_a, tl_outs_a(29));
        tick();
        chk("abort e30 state", state_a, tl_state_a(30));
        chk("abort e30 outs", obs_a, tl_outs_a(30));
        tick();
        chk("abort e31 state", state_a, 3'd0);
        chk("abort e31 outs", obs_a, RST_OUTS);
        repeat (3) tick();
        run_seq(43, 1'b0, "replay");

        // PREQ already high before EOS: serviced on the first RUN cycle.
        reset_n    = 1'b0;
        if_a.eos_i = 1'b0;
        tick();
        reset_n     = 1'b1;
        prog_allow  = 1'b1;
        if_a.preq_i = 1'b1;
        repeat (3) tick();
        chk("early preq idle state", state_a, 3'd0);
        chk("early preq idle outs", obs_a, RST_OUTS);
        run_seq(43, 1'b0, "early_preq");
        tick();
        chk("early preq e44 state", state_a, 3'd6);
        chk("early preq e44 pack", if_a.pack_o, 1'b1);
        tick();
        chk("early preq e45 pack", if_a.pack_o, 1'b1);

        // Asynchronous reset mid-PACK, observed before the next clock edge.
        #1 reset_n = 1'b0;
        #1;
        chk("async reset state", state_a, 3'd0);
        chk("async reset outs", obs_a, RST_OUTS);
        chk("async reset b_outs", obs_b, RST_OUTS);
        tick();
        chk("held reset outs", obs_a, RST_OUTS);
        $display("txn async reset: done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
